data_mem_interface: RTL and testbench
=====================================

Name: data_mem_interface

Overview:
Memory Access stage load/store unit that drives the data-memory bus through a req/ack handshake. It produces the `o_data_ready` signal that the hazard controller consumes to freeze IF/ID while a load or store is outstanding. It also performs RV32I byte/half/word lane steering on stores and extraction with sign or zero extension on loads. Misaligned accesses, illegal `funct3` values and bus timeouts complete without hanging the pipeline.

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum REQ-state cycles to wait for `i_bus_ack` before aborting.
- `CNT_W`, default 8: timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_mem_read`  in  1  MA instruction is a load.
- `i_mem_write`  in  1  MA instruction is a store.
- `i_funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `i_addr`  in  32  byte address from EX result.
- `i_wdata`  in  32  store data (rs2).
- `o_rdata`  out  32  aligned, extended load data.
- `o_data_ready`  out  1  high when MA holds no unfinished access; goes to the hazard controller.
- `o_misaligned`  out  1  one-cycle pulse: access rejected for misalignment.
- `o_access_err`  out  1  one-cycle pulse: illegal `funct3` or bus timeout.
- `o_bus_req`  out  1  bus request.
- `o_bus_we`  out  1  1 = write.
- `o_bus_addr`  out  32  word address, bits [1:0] forced to 0.
- `o_bus_wdata`  out  32  lane-replicated store data.
- `o_bus_be`  out  4  byte enables; all 0 for reads.
- `i_bus_ack`  in  1  bus completion; valid only while `o_bus_req` = 1.
- `i_bus_rdata`  in  32  read word, valid with `i_bus_ack`.

Behaviour:
- Reset (async, `i_rst_n` = 0):
  - State forced to IDLE.
  - `o_bus_req`/`o_bus_we`/`o_misaligned`/`o_access_err` = 0; `o_bus_be` = 0; `o_bus_addr`/`o_bus_wdata`/`o_rdata` = 0.
  - Timeout counter cleared; `o_data_ready` = 1.
- Access decode:
  - access = `i_mem_read` | `i_mem_write`.
  - If both are high, read wins and the write is ignored.
- Misalignment rule: H/HU with `addr[0]` = 1, or W with `addr[1:0]` ≠ 0.
- Illegal `funct3`: 011, 110, 111 for loads; anything other than 000/001/010 for stores.
- FSM states are IDLE, REQ, DONE, FAULT. Pipeline holds MA inputs stable while `o_data_ready` = 0.
- IDLE:
  - `o_data_ready` = !access (combinational).
  - Access, illegal `funct3` → FAULT, with `o_access_err` registered.
  - Access, misaligned → FAULT, with `o_misaligned` registered.
  - Any other access → latch address/size/data and go to REQ.
- REQ:
  - `o_bus_req` = 1, `o_data_ready` = 0; counter increments each cycle.
  - `i_bus_ack` → capture the extracted `i_bus_rdata` into `o_rdata` (loads only) and go to DONE. Ack in the first REQ cycle is legal.
  - Counter == TIMEOUT_CYCLES−1 without ack → FAULT with `o_access_err`; `o_bus_req` drops.
- DONE:
  - `o_data_ready` = 1 for exactly one cycle; pipeline advances at this edge.
  - Next state is always IDLE, never a reissue of the same access.
- FAULT:
  - `o_data_ready` = 1 for one cycle; `o_rdata` = 0; error pulse high this cycle only.
  - Next state is IDLE.
- Latency: a bus access with ack on the first REQ cycle has `o_data_ready` low for 2 cycles (IDLE, REQ) and high in DONE.
- Store steering:
  - SB: wdata = {4{`wdata[7:0]`}}, be = 0001 << `addr[1:0]`.
  - SH: wdata = {2{`wdata[15:0]`}}, be = `addr[1]` ? 1100 : 0011.
  - SW: wdata unchanged, be = 1111.
- Load extraction: word shifted right by `addr[1:0]`×8; B/H sign-extended, BU/HU zero-extended, W unchanged.
- `o_rdata` holds its value until the next completed load or fault.
- `i_bus_ack` outside REQ is ignored.
- Reset asserted mid-REQ: `o_bus_req` drops immediately (async) and the transaction is abandoned.

Decomposition:
- Package `riscv_mem_pkg` holds:
  - `funct3` localparams LB/LH/LW/LBU/LHU/SB/SH/SW.
  - State enum `mem_state_e` {IDLE, REQ, DONE, FAULT}.
  - Default TIMEOUT constant.
- One combinational sub-module `mem_load_align`: (rdata, `addr[1:0]`, `funct3`) → extended 32-bit result.
- Store steering stays inline.

Test Plan:
- LW @0x100, ack on first REQ cycle with rdata 0xDEADBEEF:
  - `o_data_ready` low 2 cycles, then high 1 cycle.
  - `o_rdata` = 0xDEADBEEF; `o_bus_addr` = 0x100, `o_bus_be` = 0000.
- LB @0x103 and LBU @0x103, rdata 0x80FF_0000:
  - LB → `o_rdata` = 0xFFFFFF80.
  - LBU → `o_rdata` = 0x00000080.
- SB @0x202 with wdata 0x12345678:
  - `o_bus_we` = 1, `o_bus_be` = 0100, `o_bus_wdata` = 0x78787878, `o_bus_addr` = 0x200.
- LH @0x101: no `o_bus_req`; `o_misaligned` pulses 1 cycle; `o_data_ready` low 1 cycle then high; `o_rdata` = 0.
- LW with ack withheld and TIMEOUT_CYCLES = 4:
  - `o_bus_req` high for exactly 4 cycles.
  - `o_access_err` pulse follows, then IDLE.
  - A late `i_bus_ack` is ignored.
- Reset mid-REQ, then release: `o_bus_req` falls within the same cycle; next LW completes normally.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Holds funct3 access codes, the unit FSM states and the default bus timeout.
package riscv_mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        FAULT
    } mem_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Load extraction: shifts the bus word down to the addressed byte lane and
// sign/zero-extends it by access size. Ports: word, off, funct3 -> result.
module mem_load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = word >> {off, 3'b000};

    always_comb begin
        result = shifted;
        case (funct3)
            LB:      result = {{24{shifted[7]}}, shifted[7:0]};
            LH:      result = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     result = {24'h0, shifted[7:0]};
            LHU:     result = {16'h0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_interface.sv
// Memory-access stage load/store unit: req/ack bus handshake, store lane
// steering, load extraction, misalign/illegal/timeout faults.
// Ports: pipeline side (i_mem_read/i_mem_write/i_funct3/i_addr/i_wdata,
// o_rdata/o_data_ready/o_misaligned/o_access_err) and bus side
// (o_bus_req/we/addr/wdata/be, i_bus_ack/i_bus_rdata).
module data_mem_interface
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter int CNT_W          = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_data_ready,
    output logic        o_misaligned,
    output logic        o_access_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lat_off;
    logic [2:0]       lat_f3;
    logic             lat_load;

    logic        access;
    logic        illegal;
    logic        misal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign access = i_mem_read | i_mem_write;

    // Read wins when both are set, so decode legality as a load then.
    always_comb begin
        if (i_mem_read)
            illegal = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                      (i_funct3 == 3'b111);
        else
            illegal = !((i_funct3 == SB) || (i_funct3 == SH) ||
                        (i_funct3 == SW));
    end

    assign misal = (((i_funct3 == LH) || (i_funct3 == LHU)) && i_addr[0]) ||
                   ((i_funct3 == LW) && (i_addr[1:0] != 2'b00));

    always_comb begin
        st_be    = 4'b0000;
        st_wdata = i_wdata;
        case (i_funct3)
            SB: begin
                st_wdata = {4{i_wdata[7:0]}};
                st_be    = 4'b0001 << i_addr[1:0];
            end
            SH: begin
                st_wdata = {2{i_wdata[15:0]}};
                st_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            end
            SW:      st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    mem_load_align u_align (
        .word   (i_bus_rdata),
        .off    (lat_off),
        .funct3 (lat_f3),
        .result (ld_data)
    );

    // Idle is transparent only when MA has nothing to do.
    assign o_data_ready = (state == IDLE) ? !access : (state != REQ);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            o_bus_req    <= 1'b0;
            o_bus_we     <= 1'b0;
            o_misaligned <= 1'b0;
            o_access_err <= 1'b0;
            o_bus_be     <= 4'b0000;
            o_bus_addr   <= 32'h0;
            o_bus_wdata  <= 32'h0;
            o_rdata      <= 32'h0;
            lat_off      <= 2'b00;
            lat_f3       <= 3'b000;
            lat_load     <= 1'b0;
        end else begin
            o_misaligned <= 1'b0;
            o_access_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (illegal) begin
                            state        <= FAULT;
                            o_access_err <= 1'b1;
                            o_rdata      <= 32'h0;
                        end else if (misal) begin
                            state        <= FAULT;
                            o_misaligned <= 1'b1;
                            o_rdata      <= 32'h0;
                        end else begin
                            state       <= REQ;
                            cnt         <= '0;
                            o_bus_req   <= 1'b1;
                            o_bus_we    <= !i_mem_read;
                            o_bus_addr  <= {i_addr[31:2], 2'b00};
                            o_bus_wdata <= st_wdata;
                            o_bus_be    <= i_mem_read ? 4'b0000 : st_be;
                            lat_off     <= i_addr[1:0];
                            lat_f3      <= i_funct3;
                            lat_load    <= i_mem_read;
                        end
                    end
                end
                REQ: begin
                    if (i_bus_ack) begin
                        state     <= DONE;
                        o_bus_req <= 1'b0;
                        o_bus_we  <= 1'b0;
                        if (lat_load)
                            o_rdata <= ld_data;
                    end else if (cnt == LAST) begin
                        state        <= FAULT;
                        o_bus_req    <= 1'b0;
                        o_bus_we     <= 1'b0;
                        o_access_err <= 1'b1;
                        o_rdata      <= 32'h0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_interface.sv
// Directed bench for data_mem_interface with a 4-cycle bus timeout.
// Hand-computed expectations checked by immediate assertions.
module tb_data_mem_interface;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        data_ready;
    logic        misaligned;
    logic        access_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int vecs = 0;
    int errs = 0;

    data_mem_interface #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_rdata      (rdata),
        .o_data_ready (data_ready),
        .o_misaligned (misaligned),
        .o_access_err (access_err),
        .o_bus_req    (bus_req),
        .o_bus_we     (bus_we),
        .o_bus_addr   (bus_addr),
        .o_bus_wdata  (bus_wdata),
        .o_bus_be     (bus_be),
        .i_bus_ack    (bus_ack),
        .i_bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_ack   = 1'b0;
    endtask

    // Full load with ack in the first REQ cycle.
    task automatic run_load(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] w,
                            input logic [31:0] exp);
        mem_read  = 1'b1;
        funct3    = f3;
        addr      = a;
        bus_rdata = w;
        #1;
        check({tag, "_rdy_idle"}, 32'(data_ready), 32'd0);
        tick();
        check({tag, "_req"}, 32'(bus_req), 32'd1);
        bus_ack = 1'b1;
        tick();
        check({tag, "_rdata"}, rdata, exp);
        check({tag, "_rdy_done"}, 32'(data_ready), 32'd1);
        idle_inputs();
        tick();
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        #1;
        check("rst_ready", 32'(data_ready), 32'd1);
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_addr", bus_addr, 32'h0);
        #12 rst_n = 1'b1;
        tick();

        // LW @0x100 with first-cycle ack
        mem_read  = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h100;
        bus_rdata = 32'hDEADBEEF;
        #1;
        check("lw_rdy_c1", 32'(data_ready), 32'd0);
        tick();
        check("lw_rdy_c2", 32'(data_ready), 32'd0);
        check("lw_req", 32'(bus_req), 32'd1);
        check("lw_we", 32'(bus_we), 32'd0);
        check("lw_addr", bus_addr, 32'h100);
        check("lw_be", 32'(bus_be), 32'd0);
        bus_ack = 1'b1;
        tick();
        check("lw_rdy_done", 32'(data_ready), 32'd1);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        check("lw_req_drop", 32'(bus_req), 32'd0);
        idle_inputs();
        tick();
        check("lw_idle_rdy", 32'(data_ready), 32'd1);

        run_load("lb", 3'b000, 32'h103, 32'h80FF0000, 32'hFFFFFF80);
        run_load("lbu", 3'b100, 32'h103, 32'h80FF0000, 32'h00000080);
        run_load("lhu", 3'b101, 32'h102, 32'h80010000, 32'h00008001);
        run_load("lh", 3'b001, 32'h102, 32'h80010000, 32'hFFFF8001);

        // SB @0x202
        mem_write = 1'b1;
        funct3    = 3'b000;
        addr      = 32'h202;
        wdata     = 32'h12345678;
        #1;
        tick();
        check("sb_we", 32'(bus_we), 32'd1);
        check("sb_be", 32'(bus_be), 32'b0100);
        check("sb_wdata", bus_wdata, 32'h78787878);
        check("sb_addr", bus_addr, 32'h200);
        bus_ack = 1'b1;
        tick();
        check("sb_rdy_done", 32'(data_ready), 32'd1);
        check("sb_rdata_hold", rdata, 32'hFFFF8001);
        idle_inputs();
        tick();

        // SH @0x202 upper half
        mem_write = 1'b1;
        funct3    = 3'b001;
        addr      = 32'h202;
        wdata     = 32'h12345678;
        #1;
        tick();
        check("sh_be", 32'(bus_be), 32'b1100);
        check("sh_wdata", bus_wdata, 32'h56785678);
        bus_ack = 1'b1;
        tick();
        idle_inputs();
        tick();

        // LH @0x101 misaligned
        mem_read = 1'b1;
        funct3   = 3'b001;
        addr     = 32'h101;
        #1;
        check("mis_rdy_c1", 32'(data_ready), 32'd0);
        tick();
        check("mis_pulse", 32'(misaligned), 32'd1);
        check("mis_req", 32'(bus_req), 32'd0);
        check("mis_rdy", 32'(data_ready), 32'd1);
        check("mis_rdata", rdata, 32'h0);
        check("mis_noerr", 32'(access_err), 32'd0);
        idle_inputs();
        tick();
        check("mis_pulse_end", 32'(misaligned), 32'd0);

        // Illegal load funct3 011
        mem_read = 1'b1;
        funct3   = 3'b011;
        addr     = 32'h100;
        #1;
        tick();
        check("ill_ld_err", 32'(access_err), 32'd1);
        check("ill_ld_req", 32'(bus_req), 32'd0);
        idle_inputs();
        tick();

        // Illegal store funct3 100
        mem_write = 1'b1;
        funct3    = 3'b100;
        #1;
        tick();
        check("ill_st_err", 32'(access_err), 32'd1);
        idle_inputs();
        tick();
        check("ill_st_end", 32'(access_err), 32'd0);

        // LW timeout with ack withheld
        run_load("pre_to", 3'b010, 32'h300, 32'h11223344, 32'h11223344);
        mem_read  = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h300;
        bus_rdata = 32'h55555555;
        #1;
        tick();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!bus_req) break;
            n++;
            tick();
        end
        check("to_req_cycles", 32'(n), 32'd4);
        check("to_err", 32'(access_err), 32'd1);
        check("to_rdy", 32'(data_ready), 32'd1);
        check("to_rdata", rdata, 32'h0);
        mem_read = 1'b0;
        bus_ack  = 1'b1;
        tick();
        check("to_err_end", 32'(access_err), 32'd0);
        check("late_ack_req", 32'(bus_req), 32'd0);
        tick();
        check("late_ack_rdata", rdata, 32'h0);
        check("late_ack_rdy", 32'(data_ready), 32'd1);
        bus_ack = 1'b0;

        // Reset in the middle of REQ
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h400;
        #1;
        tick();
        check("mid_req", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(bus_req), 32'd0);
        mem_read = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_rdy", 32'(data_ready), 32'd1);
        run_load("post_rst", 3'b010, 32'h400, 32'hCAFEF00D, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
